i2c_sensor_poller: RTL

//  Transaction sequencer that sits directly upstream of the byte-level I2C master and drives its command port.

---
 rtl/i2c_sensor_poller_pkg.sv | 30 +++
 rtl/i2c_poll_timer.sv | 39 +++
 rtl/i2c_sensor_poller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_sensor_poller_pkg.sv
// -----------------------------------------------------------------------------
// i2c_sensor_poller_pkg
//   Shared definitions for the I2C sensor poller:
//   - poll_state_e : 4-bit FSM state encoding, stable so it can be probed for
//                    debug.
//   - SENSOR_*     : default sensor bus address and register map constants.
//   - cnt_width()  : number of bits needed to hold the values 0..n-1.
// -----------------------------------------------------------------------------
package i2c_sensor_poller_pkg;

  localparam logic [6:0] SENSOR_SLAVE_ADDR = 7'h68;
  localparam logic [6:0] SENSOR_CFG_REG    = 7'h6B;
  localparam logic [7:0] SENSOR_CFG_VAL    = 8'h00;
  localparam logic [6:0] SENSOR_RD_BASE    = 7'h3B;

  typedef enum logic [3:0] {
    ST_CFG_ISSUE = 4'd0,
    ST_CFG_WAIT  = 4'd1,
    ST_PARK      = 4'd2,
    ST_RD_ISSUE  = 4'd3,
    ST_RD_WAIT   = 4'd4,
    ST_PUBLISH   = 4'd5
  } poll_state_e;

  // Width of a counter that must represent 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// -----------------------------------------------------------------------------
// i2c_poll_timer
//   Saturating down-counter used for both the frame period and the transaction
//   watchdog. It reads as expired while the count is zero.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset (count resets to 0)
//   load        : load load_val this cycle (takes priority over everything)
//   hold        : freeze the count this cycle
//   load_val    : value loaded on load
//   expired     : count == 0
// -----------------------------------------------------------------------------
module i2c_poll_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/i2c_sensor_poller.sv
// -----------------------------------------------------------------------------
// i2c_sensor_poller
//   Transaction sequencer in front of a byte-level I2C master. After reset it
//   writes CFG_VAL to CFG_REG (retrying until the write completes), then every
//   PERIOD cycles reads NUM_REGS consecutive registers starting at RD_BASE and
//   publishes the whole frame at once with a one-cycle sample_valid. A watchdog
//   aborts any transaction that gets no m_done within TIMEOUT cycles of
//   m_start, pulsing err_timeout and bumping a saturating err_count.
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : polling permitted (sampled only between frames)
//   m_start           : one-cycle command strobe to the master
//   m_read_write      : 1 = read, 0 = write
//   m_slave_addr      : sensor bus address
//   m_reg_addr        : target register
//   m_data_in         : write byte (CFG_VAL for the config write, else 0)
//   m_data_out        : byte from the master, valid while m_done = 1
//   m_busy, m_done    : master busy level / completion pulse
//   sample_data       : last complete frame, byte k = register RD_BASE+k
//   sample_valid      : one-cycle pulse when sample_data updates
//   cfg_done          : sticky, config write has completed
//   err_timeout       : one-cycle pulse per watchdog abort
//   err_count         : saturating count of aborts
// -----------------------------------------------------------------------------
module i2c_sensor_poller
  import i2c_sensor_poller_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = SENSOR_SLAVE_ADDR,
  parameter logic [6:0]  CFG_REG    = SENSOR_CFG_REG,
  parameter logic [7:0]  CFG_VAL    = SENSOR_CFG_VAL,
  parameter logic [6:0]  RD_BASE    = SENSOR_RD_BASE,
  parameter int unsigned NUM_REGS   = 6,
  parameter int unsigned PERIOD     = 100000,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  m_start,
  output logic                  m_read_write,
  output logic [6:0]            m_slave_addr,
  output logic [6:0]            m_reg_addr,
  output logic [7:0]            m_data_in,
  input  logic [7:0]            m_data_out,
  input  logic                  m_busy,
  input  logic                  m_done,
  output logic [8*NUM_REGS-1:0] sample_data,
  output logic                  sample_valid,
  output logic                  cfg_done,
  output logic                  err_timeout,
  output logic [7:0]            err_count
);

  localparam int unsigned IDX_W = cnt_width(NUM_REGS);
  localparam int unsigned PER_W = cnt_width(PERIOD);
  localparam int unsigned WD_W  = cnt_width(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(PERIOD - 1);
  localparam logic [WD_W-1:0]  WD_RELOAD  = WD_W'(TIMEOUT - 1);

  poll_state_e state_q, state_d;

  logic [IDX_W-1:0]      idx;
  logic [8*NUM_REGS-1:0] staging;

  // Decoded actions for the current cycle.
  logic issue;        // command accepted, strobe m_start next cycle
  logic cfg_ok;       // config write completed
  logic capture;      // read byte arrived
  logic abort;        // watchdog expired without m_done
  logic publish;      // copy staging to sample_data
  logic frame_start;  // leave PARK for a new frame
  logic last_byte;

  logic per_load, per_expired;
  logic [PER_W-1:0] per_load_val;
  logic wd_hold, wd_expired;

  assign last_byte = (idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    cfg_ok      = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    publish     = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      ST_CFG_ISSUE: begin
        if (!m_busy) begin
          issue   = 1'b1;
          state_d = ST_CFG_WAIT;
        end
      end
      ST_CFG_WAIT: begin
        // m_done is examined before the watchdog so a late completion wins.
        if (m_done) begin
          cfg_ok  = 1'b1;
          state_d = ST_PARK;
        end else if (wd_expired) begin
          abort   = 1'b1;
          state_d = ST_CFG_ISSUE;
        end
      end
      ST_PARK: begin
        if (enable && per_expired) begin
          frame_start = 1'b1;
          state_d     = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (!m_busy) begin
          issue   = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (m_done) begin
          capture = 1'b1;
          state_d = last_byte ? ST_PUBLISH : ST_RD_ISSUE;
        end else if (wd_expired) begin
          abort   = 1'b1;
          state_d = ST_PARK;
        end
      end
      ST_PUBLISH: begin
        publish = 1'b1;
        state_d = ST_PARK;
      end
      default: state_d = ST_CFG_ISSUE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timers
  // ---------------------------------------------------------------------------
  // The period timer reloads at each frame start and counts down freely, so
  // frames are spaced start-to-start. While parked with enable low it is kept
  // expired, which lets a re-enable start a frame on the very next cycle.
  assign per_load     = (state_q == ST_PARK) && (frame_start || !enable);
  assign per_load_val = frame_start ? PER_RELOAD : '0;

  i2c_poll_timer #(.WIDTH(PER_W)) u_period_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (per_load),
    .hold     (1'b0),
    .load_val (per_load_val),
    .expired  (per_expired)
  );

  // Loaded as m_start is registered, so it reaches zero on the TIMEOUT-th
  // cycle counted from the m_start cycle; the abort pulse follows one cycle
  // later.
  assign wd_hold = (state_q != ST_CFG_WAIT) && (state_q != ST_RD_WAIT);

  i2c_poll_timer #(.WIDTH(WD_W)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue),
    .hold     (wd_hold),
    .load_val (WD_RELOAD),
    .expired  (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // State, command and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CFG_ISSUE;
      idx          <= '0;
      m_start      <= 1'b0;
      m_read_write <= 1'b0;
      m_slave_addr <= '0;
      m_reg_addr   <= '0;
      m_data_in    <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      cfg_done     <= 1'b0;
      err_timeout  <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      m_start      <= issue;
      sample_valid <= publish;
      err_timeout  <= abort;

      // Command fields change only when a new command is issued, so they stay
      // stable through the matching m_done.
      if (issue) begin
        m_slave_addr <= SLAVE_ADDR;
        if (state_q == ST_RD_ISSUE) begin
          m_read_write <= 1'b1;
          m_reg_addr   <= RD_BASE + 7'(idx);  // 7-bit wrap is intended
          m_data_in    <= '0;
        end else begin
          m_read_write <= 1'b0;
          m_reg_addr   <= CFG_REG;
          m_data_in    <= CFG_VAL;
        end
      end

      if (cfg_ok) begin
        cfg_done <= 1'b1;
      end

      if (capture) begin
        idx <= last_byte ? '0 : idx + IDX_W'(1);
      end

      // An aborted frame simply restarts from byte 0; the partial staging
      // contents are never published.
      if (abort) begin
        idx <= '0;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end

      if (publish) begin
        sample_data <= staging;
      end
    end
  end

  // NOTE: the staging buffer has no reset: every byte is rewritten before it
  // can be published, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (capture) begin
      staging[{idx, 3'b000} +: 8] <= m_data_out;
    end
  end

endmodule
